// File: rtl/sdp_fifo_pkg.sv
// Shared constants and helpers for the simple-dual-port FIFO controller.
package sdp_fifo_pkg;

  localparam int OB_DEPTH = 2;

  function automatic int clogb2(input int depth);
    int d;
    int r;
    d = depth;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (d > 0) begin
        r = r + 1;
        d = d >> 1;
      end
    end
    return r;
  endfunction

  localparam int OB_CNT_W = clogb2(OB_DEPTH);

endpackage

// File: rtl/sdp_fifo_obuf.sv
// Two-entry registered output buffer; head entry drives the read port.
module sdp_fifo_obuf
  import sdp_fifo_pkg::*;
#(
  parameter int W = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                clr_i,
  input  logic                push_i,
  input  logic [W-1:0]        din_i,
  input  logic                pop_i,
  output logic [OB_CNT_W-1:0] cnt_o,
  output logic [W-1:0]        head_o
);

  localparam logic [OB_CNT_W-1:0] ONE = OB_CNT_W'(1);

  logic [W-1:0]        e0_q, e0_d;
  logic [W-1:0]        e1_q, e1_d;
  logic [OB_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    case ({push_i, pop_i})
      2'b10: begin
        if (cnt_q == '0) e0_d = din_i;
        else             e1_d = din_i;
        cnt_d = cnt_q + ONE;
      end
      2'b01: begin
        e0_d  = e1_q;
        cnt_d = cnt_q - ONE;
      end
      2'b11: begin
        if (cnt_q == ONE) begin
          e0_d = din_i;
        end else begin
          e0_d = e1_q;
          e1_d = din_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn || clr_i) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= '0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign head_o = e0_q;

endmodule

// File: rtl/sdp_fifo_ctrl.sv
// FWFT FIFO controller around an external 1-cycle simple-dual-port RAM.
module sdp_fifo_ctrl
  import sdp_fifo_pkg::*;
#(
  parameter  int RAM_WIDTH = 32,
  parameter  int RAM_DEPTH = 2048,
  localparam int ADDR_W    = clogb2(RAM_DEPTH-1),
  localparam int LVL_W     = clogb2(RAM_DEPTH+2)
) (
  input  logic                 clka,
  input  logic                 rstn,
  input  logic                 flush,
  input  logic                 s_valid,
  input  logic [RAM_WIDTH-1:0] s_data,
  output logic                 s_ready,
  output logic                 m_valid,
  output logic [RAM_WIDTH-1:0] m_data,
  input  logic                 m_ready,
  output logic [LVL_W-1:0]     level,
  output logic [ADDR_W-1:0]    ram_addra,
  output logic                 ram_wea,
  output logic [RAM_WIDTH-1:0] ram_dina,
  output logic [ADDR_W-1:0]    ram_addrb,
  output logic                 ram_enb,
  input  logic [RAM_WIDTH-1:0] ram_doutb
);

  localparam int OCC_W = OB_CNT_W + 1;
  localparam logic [ADDR_W-1:0] PTR_MAX = ADDR_W'(RAM_DEPTH-1);
  localparam logic [LVL_W-1:0]  RAM_MAX = LVL_W'(RAM_DEPTH);

  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    ram_cnt_q, ram_cnt_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic                inflight_q, inflight_d;
  logic [OB_CNT_W-1:0] ob_cnt;
  logic [OCC_W-1:0]    occ;
  logic                clr, wr, pop, issue;

  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == PTR_MAX) ? '0 : p + ADDR_W'(1);
  endfunction

  assign clr     = ~rstn | flush;
  assign s_ready = rstn & ~flush & (ram_cnt_q < RAM_MAX);
  assign wr      = s_valid & s_ready;
  assign m_valid = (ob_cnt != '0);
  assign pop     = m_valid & m_ready;
  assign occ     = OCC_W'(ob_cnt) + OCC_W'(inflight_q);
  // Keep buffered plus in-flight words at most OB_DEPTH after this edge
  assign issue   = ~clr & (ram_cnt_q != '0)
                 & (occ < OCC_W'(OB_DEPTH) + OCC_W'(pop));

  assign ram_wea   = wr;
  assign ram_addra = wr_ptr_q;
  assign ram_dina  = s_data;
  assign ram_enb   = issue;
  assign ram_addrb = rd_ptr_q;
  assign level     = level_q;

  always_comb begin
    wr_ptr_d   = wr ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = issue ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    ram_cnt_d  = ram_cnt_q + LVL_W'(wr) - LVL_W'(issue);
    level_d    = level_q + LVL_W'(wr) - LVL_W'(pop);
    inflight_d = issue;
  end

  always_ff @(posedge clka) begin
    if (clr) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      level_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      level_q    <= level_d;
      inflight_q <= inflight_d;
    end
  end

  sdp_fifo_obuf #(
    .W (RAM_WIDTH)
  ) u_obuf (
    .clk    (clka),
    .rstn   (rstn),
    .clr_i  (flush),
    .push_i (inflight_q),
    .din_i  (ram_doutb),
    .pop_i  (pop),
    .cnt_o  (ob_cnt),
    .head_o (m_data)
  );

endmodule

// File: tb/tb_sdp_fifo_ctrl.sv
// Bench for sdp_fifo_ctrl with a 1-cycle RAM model, depth 4, width 8.
module tb_sdp_fifo_ctrl;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int AW = 2;
  localparam int LW = 3;

  logic          clka = 1'b0;
  logic          rstn, flush, s_valid, s_ready;
  logic          m_valid, m_ready, ram_wea, ram_enb;
  logic [W-1:0]  s_data, m_data, ram_dina, ram_doutb;
  logic [LW-1:0] level;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [W-1:0]  mem [D];

  int total = 0;
  int bad   = 0;
  int wr_idx = 0;
  int rd_idx = 0;
  int npop   = 0;
  bit mon_en = 1'b0;
  logic [W-1:0] sb [$];

  typedef struct {
    bit         sv;
    logic [7:0] d;
    bit         mr;
    bit         esr;
    bit         emv;
    logic [2:0] elv;
  } vec_t;

  vec_t tv [11];

  always #5 clka = ~clka;

  sdp_fifo_ctrl #(
    .RAM_WIDTH (W),
    .RAM_DEPTH (D)
  ) dut (
    .clka      (clka),
    .rstn      (rstn),
    .flush     (flush),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .level     (level),
    .ram_addra (ram_addra),
    .ram_wea   (ram_wea),
    .ram_dina  (ram_dina),
    .ram_addrb (ram_addrb),
    .ram_enb   (ram_enb),
    .ram_doutb (ram_doutb)
  );

  always @(posedge clka) begin
    if (ram_wea) mem[ram_addra] <= ram_dina;
    if (ram_enb) ram_doutb <= mem[ram_addrb];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clka);
    #2;
  endtask

  task automatic drive(input bit sv, input logic [7:0] d,
                       input bit mr, input bit fl);
    s_valid = sv;
    s_data  = d;
    m_ready = mr;
    flush   = fl;
  endtask

  task automatic drain();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 50 && (level != '0 || m_valid); i++) tick();
    chk("drain_level", 32'(level), 0);
    m_ready = 1'b0;
  endtask

  // Scoreboard and RAM-port monitor, sampled mid-cycle
  always @(negedge clka) begin
    if (mon_en) begin
      chk("level_vs_sb", 32'(level), sb.size());
      if (!rstn || flush) begin
        chk("wea_blocked", 32'(ram_wea), 0);
        chk("enb_blocked", 32'(ram_enb), 0);
        chk("srdy_blocked", 32'(s_ready), 0);
        sb.delete();
        wr_idx = 0;
        rd_idx = 0;
      end else begin
        chk("wea_hs", 32'(ram_wea), 32'(s_valid & s_ready));
        if (ram_wea) begin
          chk("addra", 32'(ram_addra), wr_idx);
          chk("dina", 32'(ram_dina), 32'(s_data));
          wr_idx = (wr_idx + 1) % D;
        end
        if (ram_enb) begin
          chk("addrb", 32'(ram_addrb), rd_idx);
          rd_idx = (rd_idx + 1) % D;
        end
        if (m_valid && m_ready) begin
          npop++;
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL underflow: popped %0h with nothing expected",
                     m_data);
          end else begin
            chk("order", 32'(m_data), 32'(sb.pop_front()));
          end
        end
        if (s_valid && s_ready) sb.push_back(s_data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t want finish", $time);
    $fatal(1);
  end

  initial begin
    int n;
    int p0;
    int cyc;

    tv[0]  = '{1, 8'h01, 0, 1, 0, 3'd0};
    tv[1]  = '{1, 8'h02, 0, 1, 0, 3'd1};
    tv[2]  = '{1, 8'h03, 0, 1, 0, 3'd2};
    tv[3]  = '{1, 8'h04, 0, 1, 1, 3'd3};
    tv[4]  = '{1, 8'h05, 0, 1, 1, 3'd4};
    tv[5]  = '{1, 8'h06, 0, 1, 1, 3'd5};
    tv[6]  = '{1, 8'h07, 0, 0, 1, 3'd6};
    tv[7]  = '{1, 8'h07, 0, 0, 1, 3'd6};
    tv[8]  = '{1, 8'h07, 1, 0, 1, 3'd6};
    tv[9]  = '{1, 8'h07, 0, 1, 1, 3'd5};
    tv[10] = '{0, 8'h00, 0, 0, 1, 3'd6};

    rstn = 1'b0;
    drive(1'b1, 8'hEE, 1'b0, 1'b0);
    @(negedge clka);
    chk("rst_level", 32'(level), 0);
    chk("rst_mvalid", 32'(m_valid), 0);
    chk("rst_mdata", 32'(m_data), 0);
    chk("rst_srdy", 32'(s_ready), 0);
    chk("rst_wea", 32'(ram_wea), 0);
    chk("rst_enb", 32'(ram_enb), 0);
    tick();
    rstn    = 1'b1;
    s_valid = 1'b0;
    mon_en  = 1'b1;
    @(negedge clka);
    chk("rst_srdy_rise", 32'(s_ready), 1);
    tick();

    for (int i = 0; i < 11; i++) begin
      drive(tv[i].sv, tv[i].d, tv[i].mr, 1'b0);
      @(negedge clka);
      chk($sformatf("vec%0d_srdy", i), 32'(s_ready), 32'(tv[i].esr));
      chk($sformatf("vec%0d_mvalid", i), 32'(m_valid), 32'(tv[i].emv));
      chk($sformatf("vec%0d_level", i), 32'(level), 32'(tv[i].elv));
      tick();
    end
    drain();

    drive(1'b1, 8'h11, 1'b1, 1'b0);
    tick();
    s_valid = 1'b0;
    @(negedge clka);
    chk("lat_edge1_mvalid", 32'(m_valid), 0);
    tick();
    @(negedge clka);
    chk("lat_edge2_mvalid", 32'(m_valid), 0);
    tick();
    @(negedge clka);
    chk("lat_edge3_mvalid", 32'(m_valid), 1);
    chk("lat_edge3_mdata", 32'(m_data), 32'h11);
    chk("lat_edge3_level", 32'(level), 1);
    tick();
    @(negedge clka);
    chk("lat_pop_level", 32'(level), 0);
    chk("lat_pop_mvalid", 32'(m_valid), 0);
    tick();

    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
      @(negedge clka);
      chk($sformatf("stream%0d_srdy", i), 32'(s_ready), 1);
      if (i >= 3) begin
        chk($sformatf("stream%0d_level", i), 32'(level), 3);
        chk($sformatf("stream%0d_mvalid", i), 32'(m_valid), 1);
      end
      tick();
    end
    drain();

    n   = 0;
    cyc = 0;
    p0  = npop;
    while (n < 200 && cyc < 3000) begin
      drive(1'b1, 8'(n), 1'($urandom_range(0, 1)), 1'b0);
      @(negedge clka);
      if (s_ready) n++;
      tick();
      cyc++;
    end
    chk("rand_words_in", n, 200);
    drain();
    chk("rand_words_out", npop - p0, 200);

    drive(1'b1, 8'h33, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h44, 1'b0, 1'b0);
    @(negedge clka);
    chk("fl_issue_before", 32'(ram_enb), 1);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clka);
    chk("fl_srdy", 32'(s_ready), 0);
    tick();
    flush = 1'b0;
    @(negedge clka);
    chk("fl_after_mvalid", 32'(m_valid), 0);
    chk("fl_after_level", 32'(level), 0);
    tick();
    @(negedge clka);
    chk("fl_after2_mvalid", 32'(m_valid), 0);
    drive(1'b1, 8'hA5, 1'b0, 1'b0);
    tick();
    s_valid = 1'b0;
    for (int i = 0; i < 10 && !m_valid; i++) tick();
    chk("fl_first_mvalid", 32'(m_valid), 1);
    chk("fl_first_data", 32'(m_data), 32'hA5);
    drain();

    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
      tick();
    end
    s_valid = 1'b0;
    repeat (3) tick();
    @(negedge clka);
    chk("hold3_level", 32'(level), 3);
    tick();
    rstn = 1'b0;
    drive(1'b1, 8'h99, 1'b0, 1'b0);
    @(negedge clka);
    chk("midrst_srdy", 32'(s_ready), 0);
    chk("midrst_wea", 32'(ram_wea), 0);
    tick();
    rstn    = 1'b1;
    s_valid = 1'b0;
    @(negedge clka);
    chk("postrst_level", 32'(level), 0);
    chk("postrst_mvalid", 32'(m_valid), 0);
    chk("postrst_mdata", 32'(m_data), 0);
    chk("postrst_srdy", 32'(s_ready), 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
